adder_prefix_pipe: RTL and testbench

Parametrised, segmented, pipelined prefix adder/subtractor with valid/ready handshake. It supersedes the fixed-width registered-wrapper adders for timing sweeps. The WIDTH-bit operation is split into SEGS equal segments, resolved one segment per stage with a registered carry between stages. The block sits between operand producers and consumers and supports backpressure.

---
 rtl/adder_prefix_pipe.sv | 113 +++++++++++
 tb/tb_adder_prefix_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_prefix_pipe.sv
// adder_prefix_pipe: segmented pipelined Brent-Kung adder/subtractor with valid/ready handshake
module adder_prefix_pipe #(
  parameter int WIDTH = 32,
  parameter int SEGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SW = WIDTH / SEGS;
  function automatic logic [SW+1:0] bk_add(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic ci);
    logic [SW-1:0] p, pg, pp, c;
    p = x ^ y;
    pg = x & y;
    pp = p;
    for (int d = 1; d < SW; d = d * 2)
      for (int i = 2 * d - 1; i < SW; i += 2 * d) begin
        pg[i] = pg[i] | (pp[i] & pg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    for (int d = 1 << $clog2(SW); d >= 1; d = d / 2)
      for (int i = 3 * d - 1; i < SW; i += 2 * d) begin
        pg[i] = pg[i] | (pp[i] & pg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    c = '0;
    c[0] = ci;
    for (int i = 1; i < SW; i++) c[i] = pg[i-1] | (pp[i-1] & ci);
    return {pg[SW-1] | (pp[SW-1] & ci), c[SW-1], p ^ c};
  endfunction
  logic [SEGS:0]    v_q, v_d, c_q, c_d;
  logic [WIDTH-1:0] a_q [SEGS];
  logic [WIDTH-1:0] a_d [SEGS];
  logic [WIDTH-1:0] b_q [SEGS];
  logic [WIDTH-1:0] b_d [SEGS];
  logic [WIDTH-1:0] s_q [SEGS+1];
  logic [WIDTH-1:0] s_d [SEGS+1];
  logic             o_q, o_d;
  logic             out_valid_q, out_valid_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             stall;
  assign stall = out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign out_valid = out_valid_q;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
  // stage 0 latches effective operands; stage k resolves segment k-1, skews operands and carries resolved sums
  always_comb begin
    logic [SW+1:0] r;
    v_d = {v_q[SEGS-1:0], in_valid && in_ready};
    c_d = '0;
    c_d[0] = sub ? ~cin : cin;
    a_d[0] = a;
    b_d[0] = sub ? ~b : b;
    s_d[0] = '0;
    o_d = 1'b0;
    r = '0;
    for (int k = 1; k < SEGS; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
    for (int k = 1; k <= SEGS; k++) begin
      r = bk_add(a_q[k-1][(k-1)*SW +: SW], b_q[k-1][(k-1)*SW +: SW], c_q[k-1]);
      s_d[k] = s_q[k-1];
      s_d[k][(k-1)*SW +: SW] = r[SW-1:0];
      c_d[k] = r[SW+1];
      o_d = r[SW+1] ^ r[SW];
    end
  end
  // output registers load only on a valid result so the last one stays visible
  always_comb begin
    out_valid_d = v_q[SEGS];
    sum_d = v_q[SEGS] ? s_q[SEGS] : sum_q;
    cout_d = v_q[SEGS] ? c_q[SEGS] : cout_q;
    ovf_d = v_q[SEGS] ? o_q : ovf_q;
  end
  // whole pipeline advances together and freezes on stall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      s_q <= '{default: '0};
      o_q <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      o_q <= o_d;
      out_valid_q <= out_valid_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
endmodule

// File: tb/tb_adder_prefix_pipe.sv
// tb_adder_prefix_pipe: directed and streaming checks of the segmented prefix adder
module tb_adder_prefix_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic        in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] a = '0, b = '0, sum;
  logic        iv8 = 1'b0, ci8 = 1'b0, sb8 = 1'b0, or8 = 1'b1, ir8, ov8, co8, of8;
  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic        iv64 = 1'b0, ci64 = 1'b0, sb64 = 1'b0, or64 = 1'b1, ir64, ov64, co64, of64;
  logic [63:0] a64 = '0, b64 = '0, s64;
  int checks = 0;
  int errors = 0;

  adder_prefix_pipe #(.WIDTH(32), .SEGS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));
  adder_prefix_pipe #(.WIDTH(8), .SEGS(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(ci8), .sub(sb8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8));
  adder_prefix_pipe #(.WIDTH(64), .SEGS(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .cin(ci64), .sub(sb64),
    .out_valid(ov64), .out_ready(or64), .sum(s64), .cout(co64), .ovf(of64));

  function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y, input logic ci, input logic sb);
    logic [64:0] t;
    logic [63:0] m, ye, r;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ye = (sb ? ~y : y) & m;
    t = {1'b0, x & m} + {1'b0, ye} + {64'd0, sb ? ~ci : ci};
    r = t[63:0] & m;
    return {(x[w-1] == ye[w-1]) && (r[w-1] != x[w-1]), t[w], r};
  endfunction

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
    in_valid = v;
    a = x;
    b = y;
    cin = ci;
    sub = s;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (sum !== 32'd0 || cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_data got %h/%b/%b want 0/0/0", sum, cout, ovf); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (ov8 !== 1'b0 || ov64 !== 1'b0) begin errors++; $display("FAIL reset_sweep_valid got %b/%b want 0/0", ov8, ov64); end
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_carry_ripple();
    @(posedge clk); #1;
    drive(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== (k == 5)) begin errors++; $display("FAIL ripple_latency cycle %0d got %b want %b", k, out_valid, k == 5); end
    end
    checks++;
    if (sum !== 32'h0 || cout !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL ripple_result got %h/%b/%b want 00000000/1/0", sum, cout, ovf); end
  endtask

  task automatic test_subtract();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] es [3];
    logic [2:0]  vc, ec, eo;
    int n;
    va = '{32'd5, 32'd7, 32'h7FFFFFFF};
    vb = '{32'd7, 32'd5, 32'hFFFFFFFF};
    es = '{32'hFFFFFFFE, 32'h00000001, 32'h80000000};
    vc = 3'b010;
    ec = 3'b010;
    eo = 3'b100;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b1, va[i], vb[i], vc[i], 1'b1);
    end
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int c = 0; c < 12 && n < 3; c++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (sum !== es[n] || cout !== ec[n] || ovf !== eo[n])
          begin errors++; $display("FAIL sub_beat%0d got %h/%b/%b want %h/%b/%b", n, sum, cout, ovf, es[n], ec[n], eo[n]); end
        n++;
      end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL sub_count got %0d want 3", n); end
  endtask

  task automatic test_streaming();
    logic [31:0] xa [200];
    logic [31:0] xb [200];
    logic [199:0] xc, xs;
    logic [65:0] e;
    int got, extra;
    got = 0;
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      xa[i] = $urandom;
      xb[i] = $urandom;
      xc[i] = 1'($urandom_range(0, 1));
      xs[i] = 1'($urandom_range(0, 1));
    end
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          @(posedge clk); #1;
          while ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          drive(1'b1, xa[i], xb[i], xc[i], xs[i]);
          checks++;
          if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat %0d got %b want 1", i, in_ready); end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 1500 && got < 200; c++) begin
          @(negedge clk);
          if (out_valid) begin
            e = model(32, {32'd0, xa[got]}, {32'd0, xb[got]}, xc[got], xs[got]);
            checks++;
            if (sum !== e[31:0] || cout !== e[64] || ovf !== e[65])
              begin errors++; $display("FAIL stream_beat%0d got %h/%b/%b want %h/%b/%b", got, sum, cout, ovf, e[31:0], e[64], e[65]); end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 200) begin errors++; $display("FAIL stream_count got %0d want 200", got); end
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL stream_extra got %0d want 0", extra); end
  endtask

  task automatic test_backpressure();
    logic [31:0] xa [8];
    logic [31:0] xb [8];
    logic [7:0]  xc, xs;
    logic [65:0] e;
    logic [31:0] hold;
    int acc, hold_acc, got;
    acc = 0;
    got = 0;
    hold_acc = 0;
    hold = '0;
    for (int i = 0; i < 8; i++) begin
      xa[i] = 32'h11111111 * (i + 1);
      xb[i] = 32'h0F0F0F0F + 32'(i);
    end
    xc = 8'b1010_0110;
    xs = 8'b1100_1010;
    fork
      begin
        logic ok;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
          drive(1'b1, xa[i], xb[i], xc[i], xs[i]);
          ok = 1'b0;
          for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
          end
          if (!ok) begin checks++; errors++; $display("FAIL bp_accept_timeout beat %0d got 0 want 1", i); end
          acc++;
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 50 && !out_valid; t++) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b0;
        hold = sum;
        hold_acc = acc;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
          checks++;
          if (out_valid !== 1'b1 || sum !== hold) begin errors++; $display("FAIL bp_hold got %b/%h want 1/%h", out_valid, sum, hold); end
          @(posedge clk); #1;
        end
        checks++;
        if (acc != hold_acc) begin errors++; $display("FAIL bp_no_accept got %0d want %0d", acc, hold_acc); end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && got < 8; c++) begin
          @(negedge clk);
          if (out_valid) begin
            e = model(32, {32'd0, xa[got]}, {32'd0, xb[got]}, xc[got], xs[got]);
            checks++;
            if (sum !== e[31:0] || cout !== e[64] || ovf !== e[65])
              begin errors++; $display("FAIL bp_beat%0d got %h/%b/%b want %h/%b/%b", got, sum, cout, ovf, e[31:0], e[64], e[65]); end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 8) begin errors++; $display("FAIL bp_count got %0d want 8", got); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h12345678 + 32'(i), 32'h01010101, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (out_valid !== 1'b1 || sum !== 32'h13355779) begin errors++; $display("FAIL rstmid_pre got %b/%h want 1/13355779", out_valid, sum); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("FAIL rstmid_async got %b/%h/%b/%b want 0/0/0/0", out_valid, sum, cout, ovf); end
    @(posedge clk);
    #3 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flush cycle %0d got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_sweep_w8();
    logic [7:0] ta [6];
    logic [7:0] tbv [6];
    logic [7:0] ts [6];
    logic [5:0] tc, tsb, tco, tov;
    ta = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h10, 8'h3C};
    tbv = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h0F, 8'hC3};
    ts = '{8'h00, 8'h80, 8'hFE, 8'h7F, 8'h00, 8'h00};
    tc = 6'b110000;
    tsb = 6'b011100;
    tco = 6'b111001;
    tov = 6'b001010;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      iv8 = 1'b1; a8 = ta[i]; b8 = tbv[i]; ci8 = tc[i]; sb8 = tsb[i];
      @(posedge clk); #1;
      iv8 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b0) begin errors++; $display("FAIL w8_early vec %0d got %b want 0", i, ov8); end
      @(posedge clk); #1;
      checks++;
      if (ov8 !== 1'b1 || s8 !== ts[i] || co8 !== tco[i] || of8 !== tov[i])
        begin errors++; $display("FAIL w8_vec%0d got %b/%h/%b/%b want 1/%h/%b/%b", i, ov8, s8, co8, of8, ts[i], tco[i], tov[i]); end
    end
  endtask

  task automatic test_sweep_w64();
    logic [63:0] ta [4];
    logic [63:0] tbv [4];
    logic [63:0] ts [4];
    logic [3:0]  tc, tsb, tco, tov;
    ta = '{64'h00FF00FF00FF00FF, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'h0};
    tbv = '{64'h0001000100010001, 64'h0, 64'h1, 64'h0};
    ts = '{64'h0100010001000100, 64'h0, 64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    tc = 4'b1010;
    tsb = 4'b1100;
    tco = 4'b0110;
    tov = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      iv64 = 1'b1; a64 = ta[i]; b64 = tbv[i]; ci64 = tc[i]; sb64 = tsb[i];
      @(posedge clk); #1;
      iv64 = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (ov64 !== 1'b0) begin errors++; $display("FAIL w64_early vec %0d got %b want 0", i, ov64); end
      @(posedge clk); #1;
      checks++;
      if (ov64 !== 1'b1 || s64 !== ts[i] || co64 !== tco[i] || of64 !== tov[i])
        begin errors++; $display("FAIL w64_vec%0d got %b/%h/%b/%b want 1/%h/%b/%b", i, ov64, s64, co64, of64, ts[i], tco[i], tov[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_carry_ripple();
    test_subtract();
    test_streaming();
    test_backpressure();
    test_reset_mid();
    test_sweep_w8();
    test_sweep_w64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
